// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round sequencer: picks a pseudo-random mole per round, lights it
// for a difficulty-scaled on-time, collects detector verdicts and keeps score.
module mole_round_sequencer #(
   parameter int unsigned N_MOLES        = 18,
   parameter int unsigned N_ROUNDS       = 30,
   parameter int unsigned MAX_MISSES     = 5,
   parameter int unsigned GAP_TICKS      = 500,
   parameter int unsigned START_ON_TICKS = 1500,
   parameter int unsigned MIN_ON_TICKS   = 400,
   parameter int unsigned STEP_TICKS     = 50,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  tick,
   input  logic                                  start,
   input  logic                                  hit_pulse,
   input  logic                                  miss_pulse,
   output logic [N_MOLES-1:0]                    active_onehot,
   output logic                                  busy,
   output logic                                  game_over,
   output logic [$clog2(N_ROUNDS+1)-1:0]         score,
   output logic [$clog2(MAX_MISSES+1)-1:0]       misses,
   output logic [$clog2(N_ROUNDS+1)-1:0]         round_idx,
   output logic [$clog2(START_ON_TICKS+1)-1:0]   on_ticks
);

   localparam int unsigned RW     = $clog2(N_ROUNDS + 1);
   localparam int unsigned MW     = $clog2(MAX_MISSES + 1);
   localparam int unsigned OW     = $clog2(START_ON_TICKS + 1);
   localparam int unsigned IW     = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
   localparam int unsigned CMAX_A = (GAP_TICKS > START_ON_TICKS) ? GAP_TICKS : START_ON_TICKS;
   localparam int unsigned CMAX   = (CMAX_A > SETTLE_CYCLES) ? CMAX_A : SETTLE_CYCLES;
   localparam int unsigned CW     = $clog2(CMAX + 1);
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [3:0] {
      S_IDLE, S_GAP, S_PICK, S_SHOW, S_DROP, S_HIT, S_MISS, S_ADV, S_OVER
   } state_t;

   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [15:0]       lfsr, lfsr_d;
   logic [IW-1:0]     prev_idx, prev_d;
   logic [IW-1:0]     mod_idx, pick_idx;
   logic [N_MOLES-1:0] active_d;
   logic              busy_d, over_d;
   logic [RW-1:0]     score_d, round_d;
   logic [MW-1:0]     misses_d;
   logic [OW-1:0]     on_d, on_dec;

   // Mole choice: LFSR modulo mole count, bumped by one to avoid a repeat.
   always_comb begin
      mod_idx  = IW'(lfsr % 16'(N_MOLES));
      pick_idx = mod_idx;
      if (round_idx != '0 && mod_idx == prev_idx)
         pick_idx = (mod_idx == IW'(N_MOLES - 1)) ? '0 : mod_idx + IW'(1);
   end

   // Faster mole after a hit, floored at the minimum on-time.
   always_comb begin
      on_dec = OW'(MIN_ON_TICKS);
      if (32'(on_ticks) >= MIN_ON_TICKS + STEP_TICKS)
         on_dec = on_ticks - OW'(STEP_TICKS);
   end

   // Next-state and next-register values for the whole game controller.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      lfsr_d   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      prev_d   = prev_idx;
      active_d = active_onehot;
      busy_d   = busy;
      over_d   = game_over;
      score_d  = score;
      misses_d = misses;
      round_d  = round_idx;
      on_d     = on_ticks;

      case (state)
         S_IDLE, S_OVER: begin
            if (start) begin
               score_d  = '0;
               misses_d = '0;
               round_d  = '0;
               on_d     = OW'(START_ON_TICKS);
               busy_d   = 1'b1;
               over_d   = 1'b0;
               cnt_d    = '0;
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (tick) begin
               if (cnt == CW'(GAP_TICKS - 1)) state_d = S_PICK;
               else                           cnt_d   = cnt + CW'(1);
            end
         end
         S_PICK: begin
            active_d = N_MOLES'(1) << pick_idx;
            prev_d   = pick_idx;
            cnt_d    = '0;
            state_d  = S_SHOW;
         end
         S_SHOW: begin
            if (hit_pulse) begin
               active_d = '0;
               state_d  = S_HIT;
            end else if (miss_pulse) begin
               active_d = '0;
               state_d  = S_MISS;
            end else if (tick) begin
               if (cnt == CW'(on_ticks - OW'(1))) begin
                  active_d = '0;
                  cnt_d    = '0;
                  state_d  = S_DROP;
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
         end
         S_DROP: begin
            if (hit_pulse)                                state_d = S_HIT;
            else if (miss_pulse)                          state_d = S_MISS;
            else if (cnt == CW'(SETTLE_CYCLES - 1))       state_d = S_MISS;
            else                                          cnt_d   = cnt + CW'(1);
         end
         S_HIT: begin
            if (score < RW'(N_ROUNDS)) score_d = score + RW'(1);
            on_d    = on_dec;
            state_d = S_ADV;
         end
         S_MISS: begin
            if (misses < MW'(MAX_MISSES)) misses_d = misses + MW'(1);
            state_d = S_ADV;
         end
         S_ADV: begin
            if (round_idx < RW'(N_ROUNDS)) round_d = round_idx + RW'(1);
            if (round_idx == RW'(N_ROUNDS - 1) || misses == MW'(MAX_MISSES)) begin
               busy_d  = 1'b0;
               over_d  = 1'b1;
               state_d = S_OVER;
            end else begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         default: begin
            active_d = '0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         lfsr          <= LFSR_SEED;
         prev_idx      <= '0;
         active_onehot <= '0;
         busy          <= 1'b0;
         game_over     <= 1'b0;
         score         <= '0;
         misses        <= '0;
         round_idx     <= '0;
         on_ticks      <= OW'(START_ON_TICKS);
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         lfsr          <= lfsr_d;
         prev_idx      <= prev_d;
         active_onehot <= active_d;
         busy          <= busy_d;
         game_over     <= over_d;
         score         <= score_d;
         misses        <= misses_d;
         round_idx     <= round_d;
         on_ticks      <= on_d;
      end
   end

endmodule

// File: tb/tb_mole_round_sequencer.sv
// Randomized self-checking bench for mole_round_sequencer with a game-level model.
module tb_mole_round_sequencer;

   localparam int unsigned N_MOLES    = 18;
   localparam int unsigned N_ROUNDS   = 4;
   localparam int unsigned MAX_MISSES = 3;
   localparam int unsigned GAP_TICKS  = 2;
   localparam int unsigned START_ON   = 10;
   localparam int unsigned MIN_ON     = 6;
   localparam int unsigned STEP       = 2;
   localparam int unsigned SETTLE     = 8;
   localparam logic [15:0] SEED       = 16'hACE1;
   localparam int unsigned RW = $clog2(N_ROUNDS + 1);
   localparam int unsigned MW = $clog2(MAX_MISSES + 1);
   localparam int unsigned OW = $clog2(START_ON + 1);

   localparam int M_HIT = 0, M_DMISS = 1, M_SILENT = 2, M_BOTH = 3, M_EARLY = 4;

   logic clk = 1'b0, rst = 1'b1, tick = 1'b0, start = 1'b0;
   logic hit_pulse = 1'b0, miss_pulse = 1'b0;
   logic [N_MOLES-1:0] active_onehot;
   logic busy, game_over;
   logic [RW-1:0] score, round_idx;
   logic [MW-1:0] misses;
   logic [OW-1:0] on_ticks;

   int n_pass = 0, n_total = 0;
   int exp_score, exp_miss, exp_on, rounds_in_game, total_rounds, prev_lit;
   bit game_done;
   bit seen [N_MOLES];
   int lit_ticks = 0;
   int tdiv = 0;
   logic [15:0] lfsr_m, lfsr_hist;

   mole_round_sequencer #(
      .N_MOLES(N_MOLES), .N_ROUNDS(N_ROUNDS), .MAX_MISSES(MAX_MISSES),
      .GAP_TICKS(GAP_TICKS), .START_ON_TICKS(START_ON), .MIN_ON_TICKS(MIN_ON),
      .STEP_TICKS(STEP), .SETTLE_CYCLES(SETTLE), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
      .active_onehot(active_onehot), .busy(busy), .game_over(game_over),
      .score(score), .misses(misses), .round_idx(round_idx), .on_ticks(on_ticks)
   );

   always #5 clk = ~clk;

   // One tick every third clock, changed away from the sampling edge.
   always @(negedge clk) begin
      tdiv = (tdiv == 2) ? 0 : tdiv + 1;
      tick <= (tdiv == 0);
   end

   function automatic logic [15:0] galois(input logic [15:0] l);
      return (l >> 1) ^ ((l % 2 == 1) ? 16'hB400 : 16'h0000);
   endfunction

   // Reference LFSR plus the value it held one clock ago (the value a pick used).
   always @(posedge clk) begin
      if (rst) lfsr_m <= SEED;
      else     lfsr_m <= galois(lfsr_m);
      lfsr_hist <= lfsr_m;
   end

   // Ticks seen while a mole is lit.
   always @(posedge clk) begin
      if (!rst && tick && active_onehot != '0) lit_ticks <= lit_ticks + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   // At most one mole lit at any time.
   always @(negedge clk) begin
      if (!rst) check("onehot0", 32'($onehot0(active_onehot)), 32'd1);
   end

   task automatic wait_lit(output bit ok);
      int g = 0;
      while (active_onehot == '0 && g < 2000) begin @(negedge clk); g++; end
      ok = (active_onehot != '0);
   endtask

   task automatic wait_dark(output bit ok);
      int g = 0;
      while (active_onehot != '0 && g < 2000) begin @(negedge clk); g++; end
      ok = (active_onehot == '0);
   endtask

   task automatic check_lit();
      int idx = 0;
      int e;
      check("lit_onehot", 32'($onehot(active_onehot)), 32'd1);
      for (int i = 0; i < N_MOLES; i++) if (active_onehot[i]) idx = i;
      e = int'(lfsr_hist) % N_MOLES;
      if (rounds_in_game != 0 && e == prev_lit) e = (e + 1) % N_MOLES;
      check("mole_idx", 32'(idx), 32'(e));
      if (rounds_in_game != 0) check("no_repeat", 32'(idx != prev_lit), 32'd1);
      prev_lit = idx;
      seen[idx] = 1'b1;
   endtask

   task automatic start_game();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      rounds_in_game = 0; exp_score = 0; exp_miss = 0; exp_on = START_ON; game_done = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_over", 32'(game_over), 32'd0);
      check("start_score", 32'(score), 32'd0);
      check("start_misses", 32'(misses), 32'd0);
      check("start_round", 32'(round_idx), 32'd0);
      check("start_on", 32'(on_ticks), 32'(START_ON));
   endtask

   task automatic play_round(input int mode, input bit stray_start, input bit gap_poke);
      bit ok;
      bit hit;
      int t0, n;
      logic [MW-1:0] m0;
      total_rounds++;
      wait_lit(ok);
      if (!ok) begin check("lit_timeout", 32'd0, 32'd1); game_done = 1'b1; return; end
      check_lit();
      t0 = lit_ticks;
      hit = (mode == M_HIT || mode == M_BOTH);
      if (mode == M_HIT || mode == M_BOTH || mode == M_EARLY) begin
         @(negedge clk); start = stray_start;
         @(negedge clk); start = 1'b0;
         hit_pulse = hit; miss_pulse = (mode != M_HIT);
         @(negedge clk); hit_pulse = 1'b0; miss_pulse = 1'b0;
         check("dark_after_verdict", 32'(active_onehot), 32'd0);
      end else begin
         wait_dark(ok);
         if (!ok) begin check("dark_timeout", 32'd0, 32'd1); game_done = 1'b1; return; end
         check("lit_ticks", 32'(lit_ticks - t0), 32'(exp_on));
         if (mode == M_DMISS) begin
            @(negedge clk); miss_pulse = 1'b1;
            @(negedge clk); miss_pulse = 1'b0;
         end else begin
            // MISS state is entered SETTLE clocks after drop; its count lands one clock later.
            m0 = misses; n = 0;
            while (misses == m0 && n < 100) begin @(negedge clk); n++; end
            check("settle_clks", 32'(n), 32'(SETTLE + 1));
            miss_pulse = 1'b1;
            @(negedge clk); miss_pulse = 1'b0;
         end
      end
      if (hit) begin
         exp_score++;
         exp_on = (exp_on >= int'(MIN_ON + STEP)) ? exp_on - int'(STEP) : int'(MIN_ON);
      end else begin
         exp_miss++;
      end
      rounds_in_game++;
      n = 0;
      while (round_idx != RW'(rounds_in_game) && n < 100) begin @(negedge clk); n++; end
      check("round_idx", 32'(round_idx), 32'(rounds_in_game));
      check("score", 32'(score), 32'(exp_score));
      check("misses", 32'(misses), 32'(exp_miss));
      check("on_ticks", 32'(on_ticks), 32'(exp_on));
      game_done = (rounds_in_game == int'(N_ROUNDS)) || (exp_miss == int'(MAX_MISSES));
      check("busy", 32'(busy), 32'(!game_done));
      check("game_over", 32'(game_over), 32'(game_done));
      if (!game_done && gap_poke) begin
         hit_pulse = 1'b1;
         @(negedge clk); hit_pulse = 1'b0;
         @(negedge clk);
         check("gap_hit_ignored", 32'(score), 32'(exp_score));
      end
   endtask

   initial begin
      bit ok;
      int lit_cnt, guard, nseen;
      total_rounds = 0; prev_lit = 0; rounds_in_game = 0; game_done = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_active", 32'(active_onehot), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_over", 32'(game_over), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      check("rst_misses", 32'(misses), 32'd0);
      check("rst_round", 32'(round_idx), 32'd0);
      check("rst_on", 32'(on_ticks), 32'(START_ON));
      rst = 1'b0;

      // Reset in the middle of a lit mole.
      start_game();
      wait_lit(ok);
      check("t1_lit", 32'(ok), 32'd1);
      if (ok) check_lit();
      rst = 1'b1;
      @(negedge clk);
      check("t1_active", 32'(active_onehot), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_score", 32'(score), 32'd0);
      check("t1_on", 32'(on_ticks), 32'(START_ON));
      @(negedge clk); rst = 1'b0;
      lit_cnt = 0;
      repeat (200) begin @(negedge clk); if (active_onehot != '0) lit_cnt++; end
      check("t1_stays_dark", 32'(lit_cnt), 32'd0);

      // All hits: on-time walks 10, 8, 6, 6, 6.
      start_game();
      guard = 0;
      while (!game_done && guard < 10) begin play_round(M_HIT, 1'b0, 1'b0); guard++; end
      check("t2_score", 32'(score), 32'd4);
      check("t2_on", 32'(on_ticks), 32'd6);
      check("t2_over", 32'(game_over), 32'd1);
      check("t2_busy", 32'(busy), 32'd0);

      // Never hit: detector reports misses after each drop.
      start_game();
      guard = 0;
      while (!game_done && guard < 10) begin play_round(M_DMISS, 1'b0, 1'b0); guard++; end
      check("t3_misses", 32'(misses), 32'd3);
      check("t3_round", 32'(round_idx), 32'd3);
      check("t3_score", 32'(score), 32'd0);
      check("t3_over", 32'(game_over), 32'd1);

      // Silent detector then simultaneous pulses, stray start and gap hit.
      start_game();
      play_round(M_SILENT, 1'b0, 1'b1);
      play_round(M_BOTH, 1'b1, 1'b1);
      guard = 0;
      while (!game_done && guard < 10) begin play_round(M_HIT, 1'b1, 1'b1); guard++; end

      // Long random run across many games.
      guard = 0;
      while (total_rounds < 230 && guard < 400) begin
         if (game_done) start_game();
         play_round(int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
         guard++;
      end
      nseen = 0;
      for (int i = 0; i < N_MOLES; i++) if (seen[i]) nseen++;
      check("all_moles_seen", 32'(nseen), 32'(N_MOLES));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
